adc_st_packetizer: RTL and testbench

Avalon-ST source that packs a continuous, non-backpressurable ADC sample stream into 512-bit packet beats with sop/eop/empty. It is the transmitting end of the soc_system `adc_fifo_0_st_sink` interface and sits in the FPGA fabric between the ADC capture logic and the HPS-side FIFO. It absorbs sink backpressure with a small beat FIFO and accounts for every sample it loses.

---
 rtl/adc_st_pkg.sv | 26 ++
 rtl/adc_st_beat_fifo.sv | 50 +++++
 rtl/adc_st_packetizer.sv | 164 ++++++++++++++++
 tb/tb_adc_st_packetizer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_st_pkg.sv
// Shared types for the ADC Avalon-ST packetizer: FSM states, the 512-bit beat
// record carried through the beat FIFO, and the lane-count helper.
package adc_st_pkg;

  localparam int BEAT_W  = 512;
  localparam int EMPTY_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FILL,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic [BEAT_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  function automatic int lanes(input int sample_w);
    return BEAT_W / sample_w;
  endfunction

endpackage

// File: rtl/adc_st_beat_fifo.sv
// Synchronous beat FIFO; the head slot is presented directly and reads as zero
// while the FIFO is empty so the source outputs are quiet after reset.
module adc_st_beat_fifo
  import adc_st_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  beat_t din,
  output beat_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  beat_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // NOTE: storage carries no reset; validity is tracked by count alone, so the
  // array maps onto plain registers/RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/adc_st_packetizer.sv
// Packs a ready-less ADC sample stream into 512-bit Avalon-ST packets, buffering
// beats against sink backpressure and counting samples lost while a beat waits.
module adc_st_packetizer
  import adc_st_pkg::*;
#(
  parameter int SAMPLE_W   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                trigger,
  input  logic [LEN_W-1:0]    pkt_len,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [BEAT_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                src_startofpacket,
  output logic                src_endofpacket,
  output logic [EMPTY_W-1:0]  src_empty,
  output logic                busy,
  output logic                overflow,
  output logic [15:0]         drop_count,
  output logic                pkt_done
);

  localparam int NLANES = lanes(SAMPLE_W);
  localparam int LANE_W = $clog2(NLANES);

  state_t              state;
  state_t              state_nxt;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    cnt_r;
  logic [LANE_W-1:0]   lane_r;
  logic [BEAT_W-1:0]   asm_r;
  logic [BEAT_W-1:0]   beat_d;
  logic                first_r;
  beat_t               hold_r;
  beat_t               cur_beat;
  beat_t               push_beat;
  beat_t               head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                arm_ok;
  logic                take;
  logic                last_sample;
  logic                beat_done;
  logic                pop;
  logic                can_push;
  logic                push;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (arm_ok) state_nxt = ST_ARMED;
      ST_ARMED,
      ST_FILL: begin
        if (beat_done)
          state_nxt = !can_push ? ST_HOLD : (last_sample ? ST_IDLE : ST_FILL);
        else if (state == ST_ARMED && trigger)
          state_nxt = ST_FILL;
      end
      ST_HOLD:  if (can_push) state_nxt = hold_r.eop ? ST_IDLE : ST_FILL;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    arm_ok      = (state == ST_IDLE) && arm && (pkt_len != '0);
    // The trigger cycle's sample is already sample 0 of the packet.
    take        = sample_valid &&
                  ((state == ST_FILL) || (state == ST_ARMED && trigger));
    last_sample = ((cnt_r + LEN_W'(1)) == len_r);
    beat_done   = take && (last_sample || lane_r == LANE_W'(NLANES - 1));

    beat_d = asm_r;
    beat_d[BEAT_W-1-int'(lane_r)*SAMPLE_W -: SAMPLE_W] = sample_data;

    cur_beat.data  = beat_d;
    cur_beat.sop   = first_r;
    cur_beat.eop   = last_sample;
    cur_beat.empty = last_sample ?
                     EMPTY_W'((NLANES - 1 - int'(lane_r)) * SAMPLE_W / 8) : '0;

    // A pop in the same cycle frees the slot for a push into a full FIFO.
    pop       = src_valid && src_ready;
    can_push  = !fifo_full || pop;
    push_beat = (state == ST_HOLD) ? hold_r : cur_beat;
    push      = can_push && ((state == ST_HOLD) || beat_done);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_r      <= '0;
      cnt_r      <= '0;
      lane_r     <= '0;
      asm_r      <= '0;
      first_r    <= 1'b0;
      hold_r     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      pkt_done   <= 1'b0;
    end else begin
      if (arm_ok) begin
        len_r      <= pkt_len;
        cnt_r      <= '0;
        lane_r     <= '0;
        asm_r      <= '0;
        first_r    <= 1'b1;
        overflow   <= 1'b0;
        drop_count <= '0;
      end
      if (take) begin
        cnt_r <= cnt_r + LEN_W'(1);
        if (beat_done) begin
          lane_r  <= '0;
          asm_r   <= '0;
          first_r <= 1'b0;
          if (!can_push) hold_r <= cur_beat;
        end else begin
          lane_r <= lane_r + LANE_W'(1);
          asm_r  <= beat_d;
        end
      end
      // While a beat is parked every arriving sample is lost, including the
      // one in the cycle the parked beat finally drains.
      if (state == ST_HOLD && sample_valid) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      pkt_done <= push && push_beat.eop;
    end
  end

  adc_st_beat_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_beat),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign src_valid         = !fifo_empty;
  assign src_data          = head.data;
  assign src_startofpacket = head.sop;
  assign src_endofpacket   = head.eop;
  assign src_empty         = head.empty;

endmodule

// File: tb/tb_adc_st_packetizer.sv
// Directed + randomized bench for adc_st_packetizer; expected beats are derived
// from the list of accepted samples by chunking it into 16-lane beats.
module tb_adc_st_packetizer;

  localparam int SW    = 32;
  localparam int NL    = 512 / SW;

  typedef struct {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm;
  logic          trigger;
  logic [15:0]   pkt_len;
  logic          sample_valid;
  logic [SW-1:0] sample_data;
  logic [511:0]  src_data;
  logic          src_valid;
  logic          src_ready;
  logic          src_startofpacket;
  logic          src_endofpacket;
  logic [5:0]    src_empty;
  logic          busy;
  logic          overflow;
  logic [15:0]   drop_count;
  logic          pkt_done;

  int            total = 0;
  int            bad   = 0;
  obs_t          cap[$];
  logic [SW-1:0] acc[$];

  always #5 clk = ~clk;

  adc_st_packetizer dut (
    .clk               (clk),
    .reset             (reset),
    .arm               (arm),
    .trigger           (trigger),
    .pkt_len           (pkt_len),
    .sample_valid      (sample_valid),
    .sample_data       (sample_data),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_startofpacket (src_startofpacket),
    .src_endofpacket   (src_endofpacket),
    .src_empty         (src_empty),
    .busy              (busy),
    .overflow          (overflow),
    .drop_count        (drop_count),
    .pkt_done          (pkt_done)
  );

  // Inputs change 1 ns after the rising edge, so at the falling edge the
  // handshake seen here is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!reset && src_valid && src_ready)
      cap.push_back('{src_data, src_startofpacket, src_endofpacket, src_empty});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] exp_data(input int beat);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < NL; k++)
      if (beat * NL + k < acc.size()) d[511-k*SW -: SW] = acc[beat*NL+k];
    return d;
  endfunction

  task automatic arm_pkt(input int len);
    pkt_len = 16'(len);
    arm     = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_overflow_clr", overflow, 0);
    check("arm_drop_clr", drop_count, 0);
  endtask

  task automatic wait_beats(input int n, input string tag);
    int c;
    c = 0;
    while (cap.size() < n && c < 400) begin
      src_ready = ($urandom % 4) != 0;
      tick();
      c++;
    end
    check({tag, "_arrived"}, 512'(cap.size() >= n), 1);
    src_ready = 1'b1;
    repeat (4) tick();
    check({tag, "_beat_count"}, cap.size(), n);
  endtask

  task automatic compare_packet(input string tag);
    int   nb;
    obs_t b;
    nb = (acc.size() + NL - 1) / NL;
    for (int i = 0; i < nb; i++) begin
      if (cap.size() == 0) begin
        check({tag, "_missing_beat"}, 0, 1);
        break;
      end
      b = cap.pop_front();
      check({tag, "_data"}, b.data, exp_data(i));
      check({tag, "_sop"}, b.sop, i == 0);
      check({tag, "_eop"}, b.eop, i == nb - 1);
      check({tag, "_empty"}, b.empty, (i == nb - 1) ? (NL - (acc.size() - i * NL)) * SW / 8 : 0);
    end
    cap.delete();
    acc.delete();
  endtask

  // Random valid gaps and random sink readiness; samples offered before the
  // trigger are noise that must never appear in the packet.
  task automatic run_random(input int len);
    int guard;
    arm_pkt(len);
    repeat ($urandom_range(0, 3)) begin
      sample_valid = $urandom % 2;
      sample_data  = $urandom;
      tick();
    end
    trigger = 1'b1;
    guard   = 0;
    while (acc.size() < len && guard < 2000) begin
      sample_valid = ($urandom % 4) != 0;
      sample_data  = $urandom;
      src_ready    = ($urandom % 4) != 0;
      if (sample_valid) acc.push_back(sample_data);
      tick();
      trigger = 1'b0;
      guard++;
    end
    trigger      = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic finish_packet(input string tag);
    wait_beats((acc.size() + NL - 1) / NL, tag);
    compare_packet(tag);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_no_drops"}, drop_count, 0);
  endtask

  initial begin
    obs_t b;
    reset        = 1'b1;
    arm          = 1'b0;
    trigger      = 1'b0;
    pkt_len      = '0;
    sample_valid = 1'b0;
    sample_data  = '0;
    src_ready    = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_valid", src_valid, 0);
    check("rst_data", src_data, 0);
    check("rst_sop", src_startofpacket, 0);
    check("rst_eop", src_endofpacket, 0);
    check("rst_empty", src_empty, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_count, 0);
    check("rst_pkt_done", pkt_done, 0);

    // 16 back-to-back samples fill exactly one beat.
    src_ready = 1'b1;
    arm_pkt(16);
    for (int i = 0; i < 16; i++) begin
      trigger      = (i == 0);
      sample_valid = 1'b1;
      sample_data  = SW'(i);
      acc.push_back(SW'(i));
      if (i == 15) check("t1_valid_before_last", src_valid, 0);
      tick();
    end
    trigger      = 1'b0;
    sample_valid = 1'b0;
    check("t1_valid", src_valid, 1);
    check("t1_sop", src_startofpacket, 1);
    check("t1_eop", src_endofpacket, 1);
    check("t1_empty", src_empty, 0);
    check("t1_msb_lane", src_data[511:480], 0);
    check("t1_lsb_lane", src_data[31:0], 15);
    check("t1_pkt_done", pkt_done, 1);
    check("t1_busy", busy, 0);
    tick();
    check("t1_pkt_done_pulse", pkt_done, 0);
    check("t1_popped", src_valid, 0);
    finish_packet("t1");

    // Two beats, the second partly filled.
    run_random(20);
    wait_beats(2, "t2");
    if (cap.size() >= 2) begin
      b = cap[1];
      check("t2_b2_empty", b.empty, 48);
      check("t2_b2_sop", b.sop, 0);
      check("t2_b2_eop", b.eop, 1);
      check("t2_b2_zero_lanes", b.data[383:0], 0);
    end
    compare_packet("t2");

    // Single-sample packet.
    run_random(1);
    wait_beats(1, "t3");
    if (cap.size() >= 1) begin
      b = cap[0];
      check("t3_empty", b.empty, 60);
    end
    compare_packet("t3");
    check("t3_busy", busy, 0);

    for (int r = 0; r < 4; r++) begin
      run_random($urandom_range(1, 100));
      finish_packet("rand");
    end

    // Ignored controls.
    pkt_len = '0;
    arm     = 1'b1;
    tick();
    arm = 1'b0;
    check("ign_len0", busy, 0);
    trigger      = 1'b1;
    sample_valid = 1'b1;
    tick();
    trigger      = 1'b0;
    sample_valid = 1'b0;
    check("ign_trig_idle", busy, 0);
    pkt_len = 16'd4;
    arm     = 1'b1;
    trigger = 1'b1;
    tick();
    arm     = 1'b0;
    trigger = 1'b0;
    check("ign_arm_trig_armed", busy, 1);
    sample_valid = 1'b1;
    sample_data  = 32'hBAD0BAD0;
    repeat (3) tick();
    sample_valid = 1'b0;
    check("ign_armed_no_beat", src_valid, 0);
    check("ign_armed_busy", busy, 1);
    trigger      = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 32'hA1A1A1A1;
    acc.push_back(sample_data);
    tick();
    trigger     = 1'b0;
    sample_data = 32'hB2B2B2B2;
    acc.push_back(sample_data);
    pkt_len = 16'd1;
    arm     = 1'b1;
    tick();
    arm = 1'b0;
    check("ign_arm_fill_busy", busy, 1);
    check("ign_arm_fill_no_beat", src_valid, 0);
    for (int i = 0; i < 2; i++) begin
      sample_data = $urandom;
      acc.push_back(sample_data);
      tick();
    end
    sample_valid = 1'b0;
    wait_beats(1, "ign");
    if (cap.size() >= 1) begin
      b = cap[0];
      check("ign_empty", b.empty, 48);
    end
    compare_packet("ign");

    // Backpressure: four beats buffered, fifth parked, 16 samples lost.
    src_ready = 1'b0;
    arm_pkt(96);
    for (int i = 0; i < 96; i++) begin
      trigger      = (i == 0);
      sample_valid = 1'b1;
      sample_data  = 32'h1000 + SW'(i);
      if (i < 80) acc.push_back(sample_data);
      tick();
    end
    trigger      = 1'b0;
    sample_valid = 1'b0;
    check("ovf_drop16", drop_count, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_busy", busy, 1);
    check("ovf_head_valid", src_valid, 1);
    check("ovf_head_sop", src_startofpacket, 1);
    check("ovf_head_data", src_data, exp_data(0));
    repeat (3) tick();
    check("ovf_head_stable", src_data, exp_data(0));
    check("ovf_valid_held", src_valid, 1);
    src_ready    = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 32'hDEADDEAD;
    tick();
    check("ovf_release_drop", drop_count, 17);
    for (int j = 0; j < 16; j++) begin
      sample_data = 32'h2000 + SW'(j);
      acc.push_back(sample_data);
      tick();
    end
    sample_valid = 1'b0;
    check("ovf_drop_final", drop_count, 17);
    wait_beats(6, "ovf");
    compare_packet("ovf");
    check("ovf_busy_end", busy, 0);
    check("ovf_sticky", overflow, 1);

    run_random(40);
    finish_packet("post_ovf");

    // Reset in the middle of a packet after two beats have gone out.
    src_ready = 1'b1;
    arm_pkt(60);
    for (int i = 0; i < 37; i++) begin
      trigger      = (i == 0);
      sample_valid = 1'b1;
      sample_data  = $urandom;
      tick();
    end
    trigger = 1'b0;
    check("mid_two_beats", cap.size(), 2);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("mid_rst_valid", src_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", src_data, 0);
    reset = 1'b0;
    tick();
    check("mid_rst_quiet", src_valid, 0);
    cap.delete();
    acc.delete();
    run_random(20);
    finish_packet("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
